// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm blocks: time width, ring-FSM state encoding
// and the keypad "no key" code used by the alarm controller.
package alarm_pkg;

    localparam int TIME_W = 16;

    localparam logic [3:0] NOKEY = 4'hF;

    typedef enum logic [1:0] {
        RING_IDLE     = 2'b00,
        RING_RINGING  = 2'b01,
        RING_SNOOZING = 2'b10
    } ring_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_ring_controller_rise_detect.sv
// One-cycle rising-edge pulse from a level: a 1-bit history register plus AND-NOT.
module rise_detect (
    input  logic clock_i,
    input  logic reset_i,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i && !level_q;

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm ring sequencer: starts ringing on the alarm-time match edge, then handles
// snooze, stop and the unanswered-ring timeout. All outputs are registered.
module alarm_ring_controller
    import alarm_pkg::*;
#(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [TIME_W-1:0] current_time,
    input  logic [TIME_W-1:0] alarm_time,
    input  logic              alarm_on,
    input  logic              one_second,
    input  logic              snooze_button,
    input  logic              stop_button,
    output logic              sound_alarm,
    output logic              buzzer,
    output logic              snooze_active,
    output logic [1:0]        snooze_count,
    output logic              missed_alarm
);

    localparam int SEC_MAX = max_int(SNOOZE_SEC, RING_TIMEOUT_SEC);
    localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;

    localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);
    localparam logic [SEC_W-1:0] RING_LAST   = SEC_W'(RING_TIMEOUT_SEC - 1);
    localparam logic [1:0]       SNOOZE_LIM  = 2'(MAX_SNOOZE);

    logic       match;
    logic [2:0] level;
    logic [2:0] rise;
    logic       match_rise;
    logic       snooze_press;
    logic       stop_press;

    assign match = alarm_on && (current_time == alarm_time);
    assign level = {stop_button, snooze_button, match};

    for (genvar gi = 0; gi < 3; gi++) begin : g_rise
        rise_detect u_rise (
            .clock_i (clock),
            .reset_i (reset),
            .level_i (level[gi]),
            .rise_o  (rise[gi])
        );
    end

    assign match_rise   = rise[0];
    assign snooze_press = rise[1];
    assign stop_press   = rise[2];

    ring_state_e      state_q, state_d;
    logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
    logic             beep_phase_q, beep_phase_d;
    logic [1:0]       snooze_cnt_q, snooze_cnt_d;
    logic             missed_q, missed_d;
    logic             sound_alarm_q, buzzer_q, snooze_active_q;

    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        beep_phase_d = beep_phase_q;
        snooze_cnt_d = snooze_cnt_q;
        missed_d     = missed_q;

        if (!alarm_on) begin
            state_d      = RING_IDLE;
            snooze_cnt_d = 2'd0;
        end else if (stop_press) begin
            state_d      = RING_IDLE;
            snooze_cnt_d = 2'd0;
            missed_d     = 1'b0;
        end else begin
            case (state_q)
                RING_IDLE: begin
                    if (match_rise) begin
                        state_d      = RING_RINGING;
                        sec_cnt_d    = '0;
                        beep_phase_d = 1'b1;
                    end
                end
                RING_RINGING: begin
                    // A refused snooze (limit reached) does not mask the tick.
                    if (snooze_press && (snooze_cnt_q < SNOOZE_LIM)) begin
                        state_d      = RING_SNOOZING;
                        snooze_cnt_d = snooze_cnt_q + 2'd1;
                        sec_cnt_d    = '0;
                    end else if (one_second) begin
                        if (sec_cnt_q == RING_LAST) begin
                            state_d      = RING_IDLE;
                            missed_d     = 1'b1;
                            snooze_cnt_d = 2'd0;
                        end else begin
                            sec_cnt_d    = sec_cnt_q + SEC_W'(1);
                            beep_phase_d = !beep_phase_q;
                        end
                    end
                end
                RING_SNOOZING: begin
                    if (one_second) begin
                        if (sec_cnt_q == SNOOZE_LAST) begin
                            state_d      = RING_RINGING;
                            sec_cnt_d    = '0;
                            beep_phase_d = 1'b1;
                        end else begin
                            sec_cnt_d = sec_cnt_q + SEC_W'(1);
                        end
                    end
                end
                default: state_d = RING_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= RING_IDLE;
            sec_cnt_q       <= '0;
            beep_phase_q    <= 1'b0;
            snooze_cnt_q    <= 2'd0;
            missed_q        <= 1'b0;
            sound_alarm_q   <= 1'b0;
            buzzer_q        <= 1'b0;
            snooze_active_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            sec_cnt_q       <= sec_cnt_d;
            beep_phase_q    <= beep_phase_d;
            snooze_cnt_q    <= snooze_cnt_d;
            missed_q        <= missed_d;
            // Decoded from next state so the flops track the state register exactly.
            sound_alarm_q   <= (state_d == RING_RINGING);
            buzzer_q        <= (state_d == RING_RINGING) && beep_phase_d;
            snooze_active_q <= (state_d == RING_SNOOZING);
        end
    end

    assign sound_alarm   = sound_alarm_q;
    assign buzzer        = buzzer_q;
    assign snooze_active = snooze_active_q;
    assign snooze_count  = snooze_cnt_q;
    assign missed_alarm  = missed_q;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Bench for alarm_ring_controller: hand-derived vector table, directed corner
// sequences, then random stimulus against a behavioural model.
module tb_alarm_ring_controller;

    localparam int SN  = 4;
    localparam int RT  = 6;
    localparam int MXS = 2;
    localparam logic [15:0] AT = 16'h0730;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] current_time = 16'h0729;
    logic [15:0] alarm_time = AT;
    logic        alarm_on = 1'b1;
    logic        one_second = 1'b0;
    logic        snooze_button = 1'b0;
    logic        stop_button = 1'b0;
    logic        sound_alarm, buzzer, snooze_active, missed_alarm;
    logic [1:0]  snooze_count;

    alarm_ring_controller #(
        .SNOOZE_SEC(SN), .RING_TIMEOUT_SEC(RT), .MAX_SNOOZE(MXS)
    ) dut (
        .clock(clock), .reset(reset), .current_time(current_time),
        .alarm_time(alarm_time), .alarm_on(alarm_on), .one_second(one_second),
        .snooze_button(snooze_button), .stop_button(stop_button),
        .sound_alarm(sound_alarm), .buzzer(buzzer), .snooze_active(snooze_active),
        .snooze_count(snooze_count), .missed_alarm(missed_alarm)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Behavioural model: ringing counts ticks up from its start (buzzer on even
    // counts), snooze counts down from SN.
    localparam int M_QUIET = 0, M_BELL = 1, M_NAP = 2;
    int m_mode = M_QUIET, m_bell_ticks = 0, m_nap_left = 0, m_naps = 0;
    bit m_missed = 0, m_pm = 0, m_ps = 0, m_pt = 0;

    task automatic model_edge();
        bit m, mr, sp, tp;
        if (reset) begin
            m_mode = M_QUIET; m_bell_ticks = 0; m_nap_left = 0; m_naps = 0;
            m_missed = 0; m_pm = 0; m_ps = 0; m_pt = 0;
            return;
        end
        m  = alarm_on && (current_time == alarm_time);
        mr = m && !m_pm;
        sp = snooze_button && !m_ps;
        tp = stop_button && !m_pt;
        m_pm = m; m_ps = snooze_button; m_pt = stop_button;
        if (!alarm_on) begin
            m_mode = M_QUIET; m_naps = 0;
        end else if (tp) begin
            m_mode = M_QUIET; m_naps = 0; m_missed = 0;
        end else if (m_mode == M_QUIET) begin
            if (mr) begin m_mode = M_BELL; m_bell_ticks = 0; end
        end else if (m_mode == M_BELL) begin
            if (sp && m_naps < MXS) begin
                m_mode = M_NAP; m_naps++; m_nap_left = SN;
            end else if (one_second) begin
                m_bell_ticks++;
                if (m_bell_ticks == RT) begin
                    m_mode = M_QUIET; m_missed = 1; m_naps = 0;
                end
            end
        end else begin
            if (one_second) begin
                m_nap_left--;
                if (m_nap_left == 0) begin m_mode = M_BELL; m_bell_ticks = 0; end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int es, input int eb, input int ea,
                           input int ec, input int em);
        chk({tag, ".sound"},  int'(sound_alarm),   es);
        chk({tag, ".buzzer"}, int'(buzzer),        eb);
        chk({tag, ".snza"},   int'(snooze_active), ea);
        chk({tag, ".count"},  int'(snooze_count),  ec);
        chk({tag, ".missed"}, int'(missed_alarm),  em);
    endtask

    // One clock: advance the model on the current inputs, clock the DUT, compare.
    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        cyc++;
        chk_all("model", (m_mode == M_BELL) ? 1 : 0,
                (m_mode == M_BELL && (m_bell_ticks % 2) == 0) ? 1 : 0,
                (m_mode == M_NAP) ? 1 : 0, m_naps, int'(m_missed));
    endtask

    typedef struct {
        logic rst, on; logic [15:0] ct; logic sec, snz, stp;
        int es, eb, ea, ec, em;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic on, logic [15:0] ct, logic sec,
                                logic snz, logic stp, int es, int eb, int ea,
                                int ec, int em);
        vec_t v;
        v.rst = rst; v.on = on; v.ct = ct; v.sec = sec; v.snz = snz; v.stp = stp;
        v.es = es; v.eb = eb; v.ea = ea; v.ec = ec; v.em = em;
        return v;
    endfunction

    task automatic drive(logic rst, logic on, logic [15:0] ct, logic sec, logic snz, logic stp);
        reset = rst; alarm_on = on; current_time = ct;
        one_second = sec; snooze_button = snz; stop_button = stp;
    endtask

    initial begin
        // Scenarios 1-3: match edge, buzzer toggle, snooze, snooze limit, timeout, stop.
        vecs.push_back(mk(1, 1, 16'h0729, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0729, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, AT, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, AT, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, AT, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, AT, 1, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, AT, 0, 1, 0, 0, 0, 1, 1, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, AT, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, AT, 1, 0, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, AT, 0, 1, 0, 0, 0, 1, 2, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, AT, 1, 0, 0, 0, 0, 1, 2, 0));
        vecs.push_back(mk(0, 1, AT, 1, 0, 0, 1, 1, 0, 2, 0));
        vecs.push_back(mk(0, 1, AT, 0, 1, 0, 1, 1, 0, 2, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, AT, 1, 0, 0, 1, i % 2, 0, 2, 0));
        vecs.push_back(mk(0, 1, AT, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, AT, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, AT, 1, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].on, vecs[i].ct, vecs[i].sec, vecs[i].snz, vecs[i].stp);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].es, vecs[i].eb, vecs[i].ea,
                    vecs[i].ec, vecs[i].em);
            $display("vec %0d: sound=%0d buzzer=%0d snza=%0d count=%0d missed=%0d",
                     i, sound_alarm, buzzer, snooze_active, snooze_count, missed_alarm);
        end

        // Scenario 4: stop within the matching minute does not retrigger; next day does.
        drive(0, 1, 16'h0729, 0, 0, 0); step();
        drive(0, 1, AT, 0, 0, 0); step();
        chk("s4.ring", int'(sound_alarm), 1);
        drive(0, 1, AT, 0, 0, 1); step();
        chk("s4.stop", int'(sound_alarm), 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, AT, i[0], 0, 0); step();
            chk("s4.no_retrigger", int'(sound_alarm), 0);
        end
        drive(0, 1, 16'h0729, 0, 0, 0); step();
        drive(0, 1, AT, 0, 0, 0); step();
        chk("s4.next_day", int'(sound_alarm), 1);
        $display("s4 done: sound=%0d", sound_alarm);

        // Scenario 5: snooze+stop together -> stop wins; alarm_on low clears snooze.
        drive(0, 1, AT, 0, 1, 1); step();
        chk_all("s5.stop_wins", 0, 0, 0, 0, 0);
        drive(0, 1, 16'h0729, 0, 0, 0); step();
        drive(0, 1, AT, 0, 0, 0); step();
        drive(0, 1, AT, 0, 1, 0); step();
        chk_all("s5.snoozing", 0, 0, 1, 1, 0);
        drive(0, 0, AT, 0, 0, 0); step();
        chk_all("s5.alarm_off", 0, 0, 0, 0, 0);
        drive(0, 1, AT, 0, 0, 0); step();
        chk("s5.reenable_rings", int'(sound_alarm), 1);
        $display("s5 done: sound=%0d count=%0d", sound_alarm, snooze_count);

        // Scenario 6: reset mid-snooze with the snooze button held through reset.
        drive(0, 1, AT, 0, 1, 0); step();
        chk_all("s6.snoozing", 0, 0, 1, 1, 0);
        drive(1, 1, AT, 0, 1, 0); step();
        chk_all("s6.reset", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 16'h0000, 1, 1, 0); step();
            chk_all("s6.held_button", 0, 0, 0, 0, 0);
        end
        drive(0, 1, 16'h0000, 0, 0, 0); step();
        $display("s6 done: sound=%0d snza=%0d count=%0d", sound_alarm, snooze_active, snooze_count);

        // Random phase, checked against the model inside step().
        for (int i = 0; i < 4000; i++) begin
            logic [15:0] ct;
            logic sec;
            ct  = current_time;
            sec = !one_second && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: ct = 16'h0729;
                    1, 2: ct = AT;
                    default: ct = 16'h1200;
                endcase
            end
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 39) != 0, ct, sec,
                  ($urandom_range(0, 5) == 0) ? !snooze_button : snooze_button,
                  ($urandom_range(0, 11) == 0) ? !stop_button : stop_button);
            step();
        end
        $display("random phase done: cycles=%0d", cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
